piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8: number of payload bits per frame; legal range 2..32.
REQ-002 Parameter PARITY_EN, default 1: when 1, one even-parity bit follows the payload.
REQ-003 Parameter MSB_FIRST, default 1: payload bit order; 1 = MSB first, 0 = LSB first.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port resetn, input, 1: asynchronous, active-low reset.
REQ-006 Port data_in, input, WIDTH: parallel word to transmit.
REQ-007 Port data_valid, input, 1: data_in is valid.
REQ-008 Port data_ready, output, 1: block can accept a word this cycle.
REQ-009 Port ser_out, output, 1: serial line; feeds the serial input of the downstream shift register.
REQ-010 Port frame, output, 1: high on every cycle in which ser_out carries a start, payload or parity bit.
REQ-011 Port done, output, 1: one-cycle pulse when a frame completes.

Function
REQ-012 Accept occurs on a rising edge where data_valid=1 and data_ready=1; data_in is captured into an internal WIDTH-bit shift register on that edge.
REQ-013 data_ready shall be 1 only in state IDLE; data_valid and data_in are ignored in all other states.
REQ-014 States: IDLE -> START on accept; START -> DATA after 1 cycle; DATA -> PARITY after WIDTH cycles if PARITY_EN=1, else -> IDLE; PARITY -> IDLE after 1 cycle.
REQ-015 IDLE: ser_out=0, frame=0.
REQ-016 START: ser_out=1, frame=1 for exactly one cycle, beginning the cycle after accept.
REQ-017 DATA: one payload bit per cycle in MSB_FIRST order; frame=1; a bit counter of width clog2(WIDTH+1) counts 0..WIDTH-1 and then clears.
REQ-018 PARITY: ser_out equals the XOR of all captured payload bits (even parity); frame=1.
REQ-019 done shall pulse high for exactly one cycle: the first IDLE cycle after the last frame bit; data_ready is also 1 in that cycle.
REQ-020 Back-to-back operation: an accept in the done cycle starts the next START on the following cycle; gap on the line is exactly one idle cycle.
REQ-021 Total frame length on the line is 1+WIDTH+PARITY_EN cycles; latency from the accept edge to the first frame cycle is 1 cycle.
REQ-022 ser_out, frame, done and data_ready shall be driven directly from registers or from state decode only, with no combinational path from data_valid.
REQ-023 Parity is computed on the captured word, not on live data_in.

Reset
REQ-024 While resetn=0: state=IDLE, shift register=0, bit counter=0, ser_out=0, frame=0, done=0. data_ready=1 after deassertion.
REQ-025 Reset asserted mid-frame aborts the frame immediately with no done pulse; the first accept after deassertion starts a fresh frame.

Structure
REQ-026 A shared package piso_pkg shall hold the state enum (IDLE, START, DATA, PARITY) and the default WIDTH constant.
REQ-027 The bit counter shall be a sub-module bit_counter with inputs clk, resetn, clear and en, and output count.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, PARITY_EN=1; accept 0xA5 -> ser_out over frame = 1,1,0,1,0,0,1,0,1,0, frame high for 10 cycles, done pulses on cycle 11.
REQ-029 MSB_FIRST=0; accept 0x01 -> ser_out = 1,1,0,0,0,0,0,0,0,parity 1.
REQ-030 data_valid held at 1 with changing data_in during a frame -> data_ready=0, words ignored; next accept occurs only in the done cycle.
REQ-031 Two back-to-back accepts of 0xFF and 0x00 -> frames separated by exactly one cycle with frame=0; parities 0 and 0.
REQ-032 resetn pulsed low during the 4th payload bit -> outputs go to 0 asynchronously, no done pulse, and a new 0x3C frame transmits correctly afterwards.
REQ-033 PARITY_EN=0, WIDTH=4; accept 0x9 -> ser_out = 1,1,0,0,1; frame high for 5 cycles.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the serial frame transmitter.
package piso_pkg;

  // Transmitter frame phases.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Fold one more transmitted bit into a running even-parity accumulator.
  function automatic logic parity_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

endpackage

// File: rtl/piso_tx_bit_counter.sv
// Payload bit counter: synchronous clear has priority over increment.
module bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_r;

  // Count enabled cycles, returning to zero on clear or reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (en) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out frame transmitter: start bit, payload, optional even parity.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             frame,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic             parity_r;
  logic             ser_r;
  logic             frame_r;
  logic             done_r;

  logic [CW-1:0]    count_s;
  logic             cnt_en_s;
  logic             cnt_clear_s;
  logic             last_bit_s;
  logic             head_bit_s;
  logic [WIDTH-1:0] shreg_shift_s;

  bit_counter #(.CW(CW)) u_bit_counter (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cnt_clear_s),
    .en     (cnt_en_s),
    .count  (count_s)
  );

  // Counter control and next-bit selection from the shift register head.
  always_comb begin
    cnt_en_s      = 1'b0;
    last_bit_s    = 1'b0;
    cnt_clear_s   = 1'b1;
    head_bit_s    = 1'b0;
    shreg_shift_s = shreg_r;
    if (state_r == DATA) begin
      cnt_en_s    = 1'b1;
      last_bit_s  = (count_s == LAST_IDX);
      cnt_clear_s = last_bit_s;
    end else begin
      cnt_en_s    = 1'b0;
      cnt_clear_s = 1'b1;
    end
    if (MSB_FIRST != 0) begin
      head_bit_s    = shreg_r[WIDTH-1];
      shreg_shift_s = {shreg_r[WIDTH-2:0], 1'b0};
    end else begin
      head_bit_s    = shreg_r[0];
      shreg_shift_s = {1'b0, shreg_r[WIDTH-1:1]};
    end
  end

  // Frame sequencer; each line output is registered one cycle ahead of its phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      shreg_r  <= {WIDTH{1'b0}};
      parity_r <= 1'b0;
      ser_r    <= 1'b0;
      frame_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (data_valid) begin
            state_r  <= START;
            shreg_r  <= data_in;
            parity_r <= 1'b0;
            ser_r    <= 1'b1;
            frame_r  <= 1'b1;
          end else begin
            ser_r    <= 1'b0;
            frame_r  <= 1'b0;
          end
        end
        START: begin
          state_r  <= DATA;
          ser_r    <= head_bit_s;
          frame_r  <= 1'b1;
          parity_r <= parity_step(parity_r, head_bit_s);
          shreg_r  <= shreg_shift_s;
        end
        DATA: begin
          if (last_bit_s) begin
            if (PARITY_EN != 0) begin
              state_r <= PARITY;
              ser_r   <= parity_r;
              frame_r <= 1'b1;
            end else begin
              state_r <= IDLE;
              ser_r   <= 1'b0;
              frame_r <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            ser_r    <= head_bit_s;
            frame_r  <= 1'b1;
            parity_r <= parity_step(parity_r, head_bit_s);
            shreg_r  <= shreg_shift_s;
          end
        end
        PARITY: begin
          state_r <= IDLE;
          ser_r   <= 1'b0;
          frame_r <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          ser_r   <= 1'b0;
          frame_r <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = (state_r == IDLE);
  assign ser_out    = ser_r;
  assign frame      = frame_r;
  assign done       = done_r;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: three configurations driven from one clock.
module tb_piso_tx;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  dv;
  logic [31:0] din [3];
  logic [2:0]  rdy, ser, frm, dn;

  int total = 0;
  int bad   = 0;

  int wcfg [3] = '{8, 8, 4};
  int pcfg [3] = '{1, 1, 0};
  int mcfg [3] = '{1, 0, 1};

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .PARITY_EN(1), .MSB_FIRST(1)) u_msb (
    .clk(clk), .resetn(resetn), .data_in(din[0][7:0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .ser_out(ser[0]), .frame(frm[0]), .done(dn[0]));

  piso_tx #(.WIDTH(8), .PARITY_EN(1), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .resetn(resetn), .data_in(din[1][7:0]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .ser_out(ser[1]), .frame(frm[1]), .done(dn[1]));

  piso_tx #(.WIDTH(4), .PARITY_EN(0), .MSB_FIRST(1)) u_nopar (
    .clk(clk), .resetn(resetn), .data_in(din[2][3:0]), .data_valid(dv[2]),
    .data_ready(rdy[2]), .ser_out(ser[2]), .frame(frm[2]), .done(dn[2]));

  // Wait (bounded) for ready, present one word, return at the negedge of the START cycle.
  task automatic send(input int k, input logic [31:0] d);
    int n;
    n = 0;
    while (rdy[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rdy[k] !== 1'b1) begin
      $display("FAIL ready_wait dut%0d: data_ready=%b expected 1", k, rdy[k]);
      bad++;
    end
    dv[k]  = 1'b1;
    din[k] = d;
    @(negedge clk);
    dv[k]  = 1'b0;
  endtask

  // Compare the line against the frame implied by the word; ends at the done-cycle negedge.
  task automatic check_frame(input int k, input logic [31:0] d, input bit noisy);
    logic exp_q [$];
    int   ones;
    int   w;
    logic b;
    w    = wcfg[k];
    ones = 0;
    exp_q.push_back(1'b1);
    for (int i = 0; i < w; i++) begin
      b = (mcfg[k] != 0) ? d[w-1-i] : d[i];
      exp_q.push_back(b);
      ones += int'(b);
    end
    if (pcfg[k] != 0) exp_q.push_back(ones % 2 == 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (noisy) begin
        dv[k]  = 1'b1;
        din[k] = $urandom;
      end
      total++;
      if (ser[k] !== exp_q[i] || frm[k] !== 1'b1 || rdy[k] !== 1'b0 || dn[k] !== 1'b0) begin
        $display("FAIL frame_bit dut%0d data=%h cycle=%0d: ser=%b frame=%b ready=%b done=%b, expected ser=%b frame=1 ready=0 done=0",
                 k, d, i + 1, ser[k], frm[k], rdy[k], dn[k], exp_q[i]);
        bad++;
      end
      @(negedge clk);
    end
    total++;
    if (dn[k] !== 1'b1 || rdy[k] !== 1'b1 || frm[k] !== 1'b0 || ser[k] !== 1'b0) begin
      $display("FAIL done_cycle dut%0d data=%h: done=%b ready=%b frame=%b ser=%b, expected 1 1 0 0",
               k, d, dn[k], rdy[k], frm[k], ser[k]);
      bad++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    dv     = 3'b000;
    for (int k = 0; k < 3; k++) din[k] = 32'd0;
    repeat (3) @(negedge clk);
    total++;
    if (ser !== 3'b000 || frm !== 3'b000 || dn !== 3'b000) begin
      $display("FAIL reset_outputs: ser=%b frame=%b done=%b, expected all 0", ser, frm, dn);
      bad++;
    end
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (rdy !== 3'b111 || dn !== 3'b000 || frm !== 3'b000) begin
      $display("FAIL reset_release: ready=%b done=%b frame=%b, expected 111 000 000", rdy, dn, frm);
      bad++;
    end
  endtask

  task automatic test_directed();
    send(0, 32'hA5);
    check_frame(0, 32'hA5, 1'b0);
    @(negedge clk);
    total++;
    if (dn[0] !== 1'b0 || frm[0] !== 1'b0) begin
      $display("FAIL done_width: done=%b frame=%b, expected 0 0", dn[0], frm[0]);
      bad++;
    end
    send(1, 32'h01);
    check_frame(1, 32'h01, 1'b0);
    send(2, 32'h9);
    check_frame(2, 32'h9, 1'b0);
  endtask

  task automatic test_random();
    int          k;
    logic [31:0] d;
    logic [31:0] mask;
    for (int it = 0; it < 30; it++) begin
      k    = $urandom_range(0, 2);
      mask = (32'd1 << wcfg[k]) - 32'd1;
      d    = $urandom & mask;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(k, d);
      check_frame(k, d, 1'b0);
    end
  endtask

  task automatic test_busy_ignore();
    send(0, 32'h3A);
    check_frame(0, 32'h3A, 1'b1);
    din[0] = 32'hC7;
    @(negedge clk);
    dv[0] = 1'b0;
    check_frame(0, 32'hC7, 1'b0);
  endtask

  task automatic test_back_to_back();
    send(0, 32'hFF);
    check_frame(0, 32'hFF, 1'b0);
    send(0, 32'h00);
    check_frame(0, 32'h00, 1'b0);
    send(1, 32'hFF);
    check_frame(1, 32'hFF, 1'b0);
    send(1, 32'h00);
    check_frame(1, 32'h00, 1'b0);
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    send(0, 32'h5B);
    repeat (4) @(negedge clk);
    total++;
    if (frm[0] !== 1'b1) begin
      $display("FAIL midframe_active: frame=%b expected 1", frm[0]);
      bad++;
    end
    resetn = 1'b0;
    #1;
    total++;
    if (ser[0] !== 1'b0 || frm[0] !== 1'b0 || dn[0] !== 1'b0) begin
      $display("FAIL async_abort: ser=%b frame=%b done=%b, expected 0 0 0", ser[0], frm[0], dn[0]);
      bad++;
    end
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (dn[0] !== 1'b0 || frm[0] !== 1'b0 || rdy[0] !== 1'b1) begin
        $display("FAIL post_abort cycle=%0d: done=%b frame=%b ready=%b, expected 0 0 1", i, dn[0], frm[0], rdy[0]);
        bad++;
      end
    end
    send(0, 32'h3C);
    check_frame(0, 32'h3C, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midframe();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
